// File: rtl/partition_sweep_checker.sv
// Exhaustive sweep of an exact/approximate partition pair with on-chip error metrics.
// Every NI-bit vector is held for SETTLE cycles, then both outputs are compared once.
module partition_sweep_checker #(
    parameter int NI     = 8,
    parameter int NO     = 5,
    parameter int SETTLE = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic [NI-1:0]                  stim_o,
    input  logic [NO-1:0]                  exact_i,
    input  logic [NO-1:0]                  approx_i,
    output logic                           busy,
    output logic                           done,
    output logic [NI:0]                    err_count,
    output logic [NI+$clog2(NO+1)-1:0]     hd_sum,
    output logic [NO-1:0]                  max_abs_err,
    output logic [NI-1:0]                  first_fail_vec,
    output logic                           first_fail_valid
);
    // state  | meaning
    // IDLE   | waiting for start; results from an aborted sweep stay frozen
    // SETTLE | vector on stim_o, letting both partitions settle
    // SAMPLE | one cycle: compare exact_i/approx_i and advance the vector
    // DONE   | sweep finished, metrics final until the next start

    localparam int HW = $clog2(NO + 1);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [NI-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {IDLE, SETTLE_S, SAMPLE, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   settle_cnt;
    logic [NO-1:0]   diff_bits;
    logic [NO-1:0]   abs_diff;
    logic [HW-1:0]   diff_pop;
    logic            mismatch;

    always_comb begin
        diff_bits = exact_i ^ approx_i;
        mismatch  = |diff_bits;
        abs_diff  = (approx_i > exact_i) ? (approx_i - exact_i) : (exact_i - approx_i);
        diff_pop  = '0;
        for (int i = 0; i < NO; i++) begin
            diff_pop = diff_pop + HW'(diff_bits[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            stim_o           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            hd_sum           <= '0;
            max_abs_err      <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= SETTLE_S;
                        settle_cnt       <= '0;
                        stim_o           <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        err_count        <= '0;
                        hd_sum           <= '0;
                        max_abs_err      <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SETTLE_S: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (settle_cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                SAMPLE: begin
                    // An abort landing on the sample edge drops that sample entirely.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_count + (NI+1)'(1);
                            hd_sum    <= hd_sum + {{NI{1'b0}}, diff_pop};
                            if (abs_diff > max_abs_err) max_abs_err <= abs_diff;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= stim_o;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (stim_o == VEC_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            stim_o     <= stim_o + NI'(1);
                            settle_cnt <= '0;
                            state      <= SETTLE_S;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_partition_sweep_checker.sv
// Bench for partition_sweep_checker: a model computes sweep metrics, pushes them to a
// scoreboard at start/abort, and they are popped and compared when the DUT finishes.
module tb_partition_sweep_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, abort_a, start_b, abort_b;
    int          mode;

    logic [7:0]  stim_a;
    logic [4:0]  exact_a, approx_a, max_a;
    logic        busy_a, done_a, ffval_a;
    logic [8:0]  err_a;
    logic [10:0] hd_a;
    logic [7:0]  ffv_a;

    logic [3:0]  stim_b, d1, d2, d3;
    logic [4:0]  exact_b, approx_b, max_b;
    logic        busy_b, done_b, ffval_b;
    logic [4:0]  err_b;
    logic [6:0]  hd_b;
    logic [3:0]  ffv_b;

    partition_sweep_checker #(.NI(8), .NO(5), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .stim_o(stim_a),
        .exact_i(exact_a), .approx_i(approx_a), .busy(busy_a), .done(done_a),
        .err_count(err_a), .hd_sum(hd_a), .max_abs_err(max_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_a));

    partition_sweep_checker #(.NI(4), .NO(5), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .stim_o(stim_b),
        .exact_i(exact_b), .approx_i(approx_b), .busy(busy_b), .done(done_b),
        .err_count(err_b), .hd_sum(hd_b), .max_abs_err(max_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_b));

    function automatic logic [4:0] f_exact(input int m, input int v);
        logic [31:0] t;
        t = (v * 13 + 7) ^ (v >> 3);
        if (m == 2 && v == 'h5A) return 5'd0;
        return t[4:0];
    endfunction

    function automatic logic [4:0] f_approx(input int m, input int v);
        logic [4:0]  e;
        logic [31:0] k;
        e = f_exact(m, v);
        k = v >> 2;
        case (m)
            0:       return e;
            1:       return e ^ 5'b00001;
            2:       return (v == 'h5A) ? 5'd22 : e;
            default: return (v % 5 == 2) ? (e ^ (k[4:0] | 5'd1)) : e;
        endcase
    endfunction

    function automatic logic [4:0] f_b(input int v);
        logic [31:0] t;
        t = v * 3 + 1;
        return t[4:0];
    endfunction

    // dut_b sees a partition with 3 cycles of latency on the approximate side
    always_ff @(posedge clk) begin
        d1 <= stim_b;
        d2 <= d1;
        d3 <= d2;
    end

    always_comb begin
        exact_a  = f_exact(mode, int'(stim_a));
        approx_a = f_approx(mode, int'(stim_a));
        exact_b  = f_b(int'(stim_b));
        approx_b = f_b(int'(d3)) ^ ((d3 == 4'd9) ? 5'd3 : 5'd0);
    end

    typedef struct {
        int err;
        int hd;
        int maxe;
        int ffv;
        int ffval;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t model_a(input int m, input int nvec);
        exp_t r = '{0, 0, 0, 0, 0};
        for (int v = 0; v < nvec; v++) begin
            logic [4:0] e, a;
            int d;
            e = f_exact(m, v);
            a = f_approx(m, v);
            if (e != a) begin
                r.err++;
                r.hd += $countones(e ^ a);
                d = (int'(a) > int'(e)) ? int'(a) - int'(e) : int'(e) - int'(a);
                if (d > r.maxe) r.maxe = d;
                if (r.ffval == 0) begin r.ffv = v; r.ffval = 1; end
            end
        end
        return r;
    endfunction

    function automatic exp_t model_b();
        exp_t r = '{0, 0, 0, 0, 0};
        for (int v = 0; v < 16; v++) begin
            logic [4:0] e, a;
            int d;
            e = f_b(v);
            a = f_b(v) ^ ((v == 9) ? 5'd3 : 5'd0);
            if (e != a) begin
                r.err++;
                r.hd += $countones(e ^ a);
                d = (int'(a) > int'(e)) ? int'(a) - int'(e) : int'(e) - int'(a);
                if (d > r.maxe) r.maxe = d;
                if (r.ffval == 0) begin r.ffv = v; r.ffval = 1; end
            end
        end
        return r;
    endfunction

    task automatic sb_compare(input string tag, input int err, input int hd, input int maxe,
                              input int ffv, input int ffval);
        exp_t x;
        check({tag, "_sb_avail"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({tag, "_err_count"}, err, x.err);
            check({tag, "_hd_sum"}, hd, x.hd);
            check({tag, "_max_abs_err"}, maxe, x.maxe);
            check({tag, "_first_fail_valid"}, ffval, x.ffval);
            if (x.ffval != 0) check({tag, "_first_fail_vec"}, ffv, x.ffv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int budget, output int cyc);
        cyc = 0;
        while (!done_a && cyc < budget) begin tick(); cyc++; end
    endtask

    task automatic wait_stim_a(input int target, input string tag);
        int n = 0;
        while (int'(stim_a) != target && n < 2000) begin tick(); n++; end
        check({tag, "_reach_stim"}, stim_a, target);
    endtask

    task automatic run_full_a(input int m, input string tag, input logic hold_start);
        int cyc;
        mode    = m;
        sb.push_back(model_a(m, 256));
        start_a = 1'b1;
        tick();
        start_a = hold_start;
        check({tag, "_busy"}, busy_a, 1'b1);
        wait_done_a(2000, cyc);
        start_a = 1'b0;
        check({tag, "_done_latency"}, cyc, 512);
        sb_compare(tag, err_a, hd_a, max_a, ffv_a, ffval_a);
        check({tag, "_stim_held"}, stim_a, 8'hFF);
    endtask

    initial begin
        int cyc;
        exp_t part;
        rst_n = 1'b0; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; mode = 0;
        tick(); tick();
        check("rst_stim", stim_a, 0);
        check("rst_err", err_a, 0);
        check("rst_hd", hd_a, 0);
        check("rst_max", max_a, 0);
        check("rst_ffv", ffv_a, 0);
        check("rst_ffval", ffval_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        rst_n = 1'b1;
        tick();

        run_full_a(0, "tied", 1'b0);
        run_full_a(1, "lsb_flip", 1'b0);
        run_full_a(2, "single_5a", 1'b1);
        run_full_a(3, "scattered", 1'b0);

        // abort at vector 100, start asserted alongside to show abort wins
        mode = 3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_stim_a(100, "abort");
        part = model_a(3, 100);
        sb.push_back(part);
        sb.push_back(part);
        abort_a = 1'b1; start_a = 1'b1;
        tick();
        abort_a = 1'b0; start_a = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_stim", stim_a, 100);
        sb_compare("abort", err_a, hd_a, max_a, ffv_a, ffval_a);
        tick(); tick();
        check("abort_stim_frozen", stim_a, 100);
        sb_compare("abort_frozen", err_a, hd_a, max_a, ffv_a, ffval_a);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_idle_ignored", stim_a, 100);

        sb.push_back(model_a(3, 256));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart_stim", stim_a, 0);
        check("restart_err", err_a, 0);
        check("restart_ffval", ffval_a, 0);
        wait_done_a(2000, cyc);
        check("restart_latency", cyc, 512);
        sb_compare("restart", err_a, hd_a, max_a, ffv_a, ffval_a);

        // synchronous reset in the middle of a sweep
        mode = 1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_stim_a(37, "midrst");
        tick();
        check("midrst_err_before", err_a, 37);
        rst_n = 1'b0;
        tick();
        check("midrst_stim", stim_a, 0);
        check("midrst_err", err_a, 0);
        check("midrst_hd", hd_a, 0);
        check("midrst_max", max_a, 0);
        check("midrst_ffval", ffval_a, 0);
        check("midrst_busy", busy_a, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("midrst_stays_idle", busy_a, 0);

        // SETTLE=3, NI=4 instance: 4 cycles per vector, latency-3 approx path
        sb.push_back(model_b());
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        repeat (3) begin tick(); cyc++; end
        check("b_stim_hold", stim_b, 0);
        tick(); cyc++;
        check("b_stim_step", stim_b, 1);
        while (!done_b && cyc < 500) begin tick(); cyc++; end
        check("b_done_latency", cyc, 64);
        sb_compare("b", err_b, hd_b, max_b, ffv_b, ffval_b);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/partition_sweep_checker.md
Name: partition_sweep_checker

Overview:
- Hardware successor to per-partition exhaustive testbenches: drives all 2^NI input vectors into an exact and an approximate partition instance, samples both output words, and accumulates error metrics on-chip.
- Sits beside a partition pair in the approximate-synthesis evaluation harness; results are read after `done` instead of dumping 2^NI output lines.

Parameters:
- NI, 8, partition input width (1..16); sweep length is 2^NI vectors.
- NO, 5, partition output width (1..32).
- SETTLE, 1, cycles a vector is held before sampling (>=1).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begins a sweep; sampled only in IDLE or DONE.
- abort  input  1  stops a running sweep; results frozen.
- stim_o  output  NI  current vector to both partition instances.
- exact_i  input  NO  golden partition outputs.
- approx_i  input  NO  approximate partition outputs.
- busy  output  1  high in SETTLE/SAMPLE states.
- done  output  1  high in DONE until next start or reset.
- err_count  output  NI+1  vectors where approx_i != exact_i.
- hd_sum  output  NI+$clog2(NO+1)  summed Hamming distance.
- max_abs_err  output  NO  max |approx_i - exact_i|, unsigned operands.
- first_fail_vec  output  NI  first mismatching vector.
- first_fail_valid  output  1  first_fail_vec is meaningful.

Behaviour:
- Reset (rst_n low at edge): state IDLE; stim_o, err_count, hd_sum, max_abs_err, first_fail_vec = 0; busy, done, first_fail_valid = 0. Reset overrides every input, including mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start: clear all metrics and first_fail_valid, stim_o=0, settle counter=0, done=0, go to SETTLE.
- SETTLE: counter increments each cycle; after SETTLE cycles go to SAMPLE.
- SAMPLE, single cycle: compare exact_i and approx_i at this edge.
  - Mismatch: err_count+1; hd_sum += popcount(XOR); max_abs_err = max(current, |diff|). If !first_fail_valid, latch stim_o and set valid.
  - If stim_o == 2^NI-1, go to DONE with stim_o held. Otherwise stim_o+1, counter=0, go to SETTLE.
- Throughput: SETTLE+1 cycles per vector. done rises exactly 2^NI*(SETTLE+1) cycles after the start edge.
- The stim_o increment never wraps within a sweep; the terminal vector ends the sweep.
- abort in SETTLE/SAMPLE: go to IDLE, done=0, metrics and stim_o frozen. If abort coincides with SAMPLE, that sample is discarded. abort ignored in IDLE/DONE.
- start in SETTLE/SAMPLE: ignored. start and abort together while busy: abort wins.
- Counters are sized so they cannot overflow: err_count<=2^NI, hd_sum<=NO*2^NI.
- Outputs are registered; metrics are updated at the SAMPLE edge and visible the next cycle.

Test Plan:
- NI=8, NO=5, SETTLE=1, approx_i tied to exact_i, start pulse -> done exactly 512 cycles later; err_count=0, hd_sum=0, max_abs_err=0, first_fail_valid=0.
- approx_i = exact_i ^ 5'b00001 -> err_count=256, hd_sum=256, max_abs_err=1, first_fail_vec=0x00.
- Mismatch only at stim_o=0x5A (exact=5'b00000, approx=5'b10110) -> err_count=1, hd_sum=3, max_abs_err=22, first_fail_vec=0x5A, first_fail_valid=1.
- abort asserted while stim_o=100 -> IDLE next cycle, busy=0, done=0, metrics frozen. New start -> metrics cleared, stim_o=0, full sweep completes.
- rst_n low mid-sweep at stim_o=37 -> all outputs zero next cycle. start held high during a sweep -> no restart, done timing unchanged.
- SETTLE=3, NI=4 -> stim_o changes every 4 cycles; done 64 cycles after start; each sample uses inputs applied 3 cycles earlier.
